// File: rtl/scr_arbiter.sv
// Scratch RAM arbiter: CPU priority with a bounded-wait forced grant for DMA/debug.
// Optional SCR_ARB_STATS_EN adds saturating transfer and forced-grant counters.
module scr_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef SCR_ARB_STATS_EN
  ,
  output logic [15:0]       stat_dma_xfers,
  output logic [7:0]        stat_forced
`endif
);

  typedef enum logic {ARB = 1'b0, FORCE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                gnt_cpu, gnt_dma, dma_xfer, dma_lost;

  // Grant selection: FORCE always serves DMA; otherwise CPU has priority.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (!rst) begin
      if (state_q == FORCE) begin
        gnt_dma = 1'b1;
      end else if (cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (dma_valid) begin
        gnt_dma = 1'b1;
      end
    end
  end

  always_comb begin
    dma_ready = gnt_dma;
    cpu_stall = !rst && (state_q == FORCE) && cpu_req;
    cpu_rdata = ram_rdata;
    ram_addr  = gnt_dma ? dma_addr  : cpu_addr;
    ram_wdata = gnt_dma ? dma_wdata : cpu_wdata;
    ram_we    = 1'b0;
    if (gnt_cpu) begin
      ram_we = cpu_we;
    end else if (gnt_dma) begin
      // A dropped request in FORCE must not write.
      ram_we = dma_we && dma_valid;
    end
    dma_xfer = dma_valid && gnt_dma;
    dma_lost = dma_valid && !gnt_dma;
  end

  // Next-state, wait counter and DMA read-return path.
  always_comb begin
    state_d      = ARB;
    wait_cnt_d   = '0;
    dma_rvalid_d = dma_xfer && !dma_we;
    dma_rdata_d  = dma_rdata_q;
    if (dma_xfer && !dma_we) begin
      dma_rdata_d = ram_rdata;
    end
    if (dma_lost) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    if (state_q == ARB && dma_lost && wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
      state_d = FORCE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

`ifdef SCR_ARB_STATS_EN
  logic [15:0] stat_dma_xfers_q, stat_dma_xfers_d;
  logic [7:0]  stat_forced_q, stat_forced_d;

  always_comb begin
    stat_dma_xfers_d = stat_dma_xfers_q;
    stat_forced_d    = stat_forced_q;
    if (dma_xfer && stat_dma_xfers_q != '1) begin
      stat_dma_xfers_d = stat_dma_xfers_q + 16'(1);
    end
    if (state_q == ARB && state_d == FORCE && stat_forced_q != '1) begin
      stat_forced_d = stat_forced_q + 8'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dma_xfers_q <= '0;
      stat_forced_q    <= '0;
    end else begin
      stat_dma_xfers_q <= stat_dma_xfers_d;
      stat_forced_q    <= stat_forced_d;
    end
  end

  assign stat_dma_xfers = stat_dma_xfers_q;
  assign stat_forced    = stat_forced_q;
`endif

endmodule

// File: doc/scr_arbiter.md
Name: scr_arbiter

Overview:
Arbitrates the single-port scratch RAM between the CPU execute stage (stack, ST/LD, CALL/RET) and an external DMA/debug requester. The CPU has priority; a wait counter bounds DMA starvation by forcing one DMA grant and stalling the CPU for that cycle. The block sits between the execute-stage scratch address/data muxes, the SCRATCH_RAM instance and the pipeline stall logic.

Parameters:
ADDR_W, 8, scratch RAM address width
DATA_W, 10, scratch RAM data width (holds 10-bit return addresses)
MAX_WAIT, 4, consecutive DMA wait cycles before a forced grant; legal range 1..15
WAIT_W, 4, width of the wait counter; must satisfy MAX_WAIT <= 2^WAIT_W - 1

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  execute stage needs RAM this cycle (read or write)
cpu_we  in  1  CPU write enable; qualified by cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data to CPU; combinational pass-through of ram_rdata
cpu_stall  out  1  CPU access not serviced this cycle; combinational; the pipeline holds the execute stage
dma_valid  in  1  DMA request; once asserted, held with stable fields until accepted
dma_ready  out  1  DMA granted this cycle; combinational
dma_we  in  1  DMA write enable
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_rvalid  out  1  registered; one-cycle pulse with read data
dma_rdata  out  DATA_W  registered DMA read data
ram_we  out  1  to SCRATCH_RAM WE
ram_addr  out  ADDR_W  to SCRATCH_RAM ADDR
ram_wdata  out  DATA_W  to SCRATCH_RAM DATA_IN
ram_rdata  in  DATA_W  from SCRATCH_RAM DATA_OUT (asynchronous read)

Behaviour:
- Reset, rst high at an edge: state ARB, wait_cnt 0, dma_rvalid 0, dma_rdata 0.
- While rst is high: ram_we 0, dma_ready 0, cpu_stall 0, regardless of state.
- Grant is chosen combinationally each cycle and is either CPU, DMA or none.
- Muxing: ram_addr, ram_wdata and ram_we follow the granted side. ram_we = granted side's we. With no grant: ram_we 0, ram_addr = cpu_addr.
- State ARB:
  - cpu_req=1: CPU granted; dma_ready 0; cpu_stall 0.
  - cpu_req=0 and dma_valid=1: DMA granted; dma_ready 1.
- State FORCE:
  - DMA granted and dma_ready 1 unconditionally.
  - cpu_stall = cpu_req; the CPU access must not reach the RAM.
- DMA transfer: dma_valid & dma_ready at a rising edge.
  - A write is committed that cycle.
  - A read loads dma_rdata <= ram_rdata; dma_rvalid is 1 for the following cycle only, otherwise 0.
- wait_cnt:
  - Increments, saturating, at each edge where dma_valid=1 and dma_ready=0.
  - Clears on a DMA transfer or when dma_valid=0.
- State transitions:
  - ARB -> FORCE when wait_cnt = MAX_WAIT-1 and DMA is still waiting at the edge, so FORCE is entered after exactly MAX_WAIT lost cycles.
  - FORCE -> ARB always after one cycle; exactly one transfer per FORCE; wait_cnt cleared.
  - If dma_valid drops in FORCE (protocol violation): no transfer, return to ARB.
- Back-to-back DMA is allowed in ARB while cpu_req=0, one transfer per cycle, no bubble.
- Worst-case CPU impact: one stall per MAX_WAIT+1 cycles of continuous contention.
- Simultaneous cpu_req and dma_valid in ARB with wait_cnt < MAX_WAIT-1: CPU wins.
- Reset asserted in FORCE: no RAM write that cycle; next state ARB; the DMA request stays pending.
- cpu_rdata is always ram_rdata. The CPU samples it only when cpu_req=1 and cpu_stall=0.

Optional Feature:
SCR_ARB_STATS_EN:
- Defined: adds outputs stat_dma_xfers (16 bit) and stat_forced (8 bit).
  - stat_dma_xfers: saturating count of DMA transfers.
  - stat_forced: saturating count of FORCE entries.
  - Both cleared by rst.
- Undefined: no ports, no counters; all other behaviour identical.

Test Plan:
- CPU-only writes to 0x10..0x13 with data 0x3A0..0x3A3, then reads back: RAM contains 0x3A0..0x3A3; cpu_rdata matches; cpu_stall never 1; dma_ready stays 0.
- DMA-only read of 0x10 with cpu_req=0: dma_ready=1 in the same cycle; dma_rvalid=1 next cycle with dma_rdata=0x3A0, then 0.
- Contention, MAX_WAIT=4: cpu_req held 1, DMA write 0x155 to 0x80 asserted at cycle 0.
  - dma_ready=0 for cycles 0..3.
  - Cycle 4: FORCE; dma_ready=1, cpu_stall=1, ram_we=1, ram_addr=0x80.
  - Cycle 5: CPU served, cpu_stall=0; wait_cnt=0.
- Continuous contention for 20 cycles with dma_valid always high: exactly 4 forced grants at cycles 4, 9, 14, 19.
- rst asserted during the FORCE cycle: ram_we=0; the location keeps its old value; the state after reset is ARB; the DMA is granted once cpu_req=0.
- With SCR_ARB_STATS_EN: 3 free DMA transfers plus 2 forced grants -> stat_dma_xfers=5, stat_forced=2; rst clears both to 0.
